// File: rtl/vertrees_rpt_merge.sv
`default_nettype none
// ============================================================================
//  Module      : vertrees_rpt_merge
//  Description : Merges report streams from two slave instances (a, b) into a
//                single registered output. Each source has its own FIFO.
//                A round-robin arbiter picks the next report. Saturating
//                per-source accept counters and a sticky stall-overflow flag
//                are also provided.
//  Revision    : 1.0 - initial release
// ============================================================================
module vertrees_rpt_merge #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rpt_a_vld,
  input  logic [DW-1:0] rpt_a_data,
  output logic          rpt_a_rdy,
  input  logic          rpt_b_vld,
  input  logic [DW-1:0] rpt_b_data,
  output logic          rpt_b_rdy,
  output logic          rpt_vld,
  output logic [DW-1:0] rpt_data,
  output logic          rpt_src,
  input  logic          rpt_rdy,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b,
  output logic          ovf_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  // Per-source views of the two input ports (index 0 = a, 1 = b)
  logic [1:0]    w_vld;
  logic [1:0]    w_rdy;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [1:0]    w_ne;
  logic [1:0]    w_full;
  logic [1:0]    w_ovf_hit;
  logic [DW-1:0] w_din  [2];
  logic [DW-1:0] w_head [2];
  logic [CW-1:0] w_cnt  [2];

  // Output slot and arbitration state
  logic          r_live;
  logic          r_vld;
  logic [DW-1:0] r_data;
  logic          r_src;
  logic          r_last;
  logic          r_ovf;
  logic          w_load;
  logic          w_gnt_b;

  assign w_vld    = {rpt_b_vld, rpt_a_vld};
  assign w_din[0] = rpt_a_data;
  assign w_din[1] = rpt_b_data;

  generate
    for (genvar s = 0; s < 2; s++) begin : g_src
      logic [DW-1:0] r_mem [DEPTH];
      logic [PW-1:0] r_wr;
      logic [PW-1:0] r_rd;
      logic [CW-1:0] r_cnt;
      logic [7:0]    r_stall;
      logic          w_stalled;

      // Extra pointer MSB distinguishes full from empty when indices match
      assign w_full[s]    = (r_wr[PW-1] != r_rd[PW-1]) && (r_wr[IW-1:0] == r_rd[IW-1:0]);
      assign w_ne[s]      = (r_wr != r_rd);
      // Ready is suppressed until the first edge after reset release
      assign w_rdy[s]     = r_live & ~w_full[s];
      assign w_push[s]    = w_vld[s] & w_rdy[s];
      assign w_head[s]    = r_mem[r_rd[IW-1:0]];
      assign w_stalled    = w_vld[s] & ~w_rdy[s];
      assign w_ovf_hit[s] = w_stalled && (r_stall == 8'hFF);
      assign w_cnt[s]     = r_cnt;

      // FIFO storage; never visible before being written, so no reset needed
      always_ff @(posedge clk) begin
        if (w_push[s]) r_mem[r_wr[IW-1:0]] <= w_din[s];
      end

      // FIFO pointers, accept counter and stall counter
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wr    <= '0;
          r_rd    <= '0;
          r_cnt   <= '0;
          r_stall <= '0;
        end else begin
          if (w_push[s]) r_wr <= r_wr + 1'b1;
          if (w_pop[s])  r_rd <= r_rd + 1'b1;
          if (w_push[s] && (r_cnt != {CW{1'b1}})) r_cnt <= r_cnt + 1'b1;
          if (!w_stalled)             r_stall <= '0;
          else if (r_stall != 8'hFF)  r_stall <= r_stall + 1'b1;
        end
      end
    end
  endgenerate

  // Round-robin: favour the source not granted last when both have data
  assign w_gnt_b  = w_ne[1] & (~w_ne[0] | ~r_last);
  assign w_load   = (~r_vld | rpt_rdy) & (|w_ne);
  assign w_pop[0] = w_load & ~w_gnt_b;
  assign w_pop[1] = w_load &  w_gnt_b;

  // Output slot, last-granted pointer and ready-enable register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
      r_vld  <= 1'b0;
      r_data <= '0;
      r_src  <= 1'b0;
      r_last <= 1'b1;
    end else begin
      r_live <= 1'b1;
      if (w_load) begin
        r_vld  <= 1'b1;
        r_data <= w_gnt_b ? w_head[1] : w_head[0];
        r_src  <= w_gnt_b;
        r_last <= w_gnt_b;
      end else if (rpt_rdy) begin
        r_vld  <= 1'b0;
      end
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_ovf <= 1'b0;
    else if (|w_ovf_hit)   r_ovf <= 1'b1;
  end

  assign rpt_a_rdy = w_rdy[0];
  assign rpt_b_rdy = w_rdy[1];
  assign rpt_vld   = r_vld;
  assign rpt_data  = r_data;
  assign rpt_src   = r_src;
  assign cnt_a     = w_cnt[0];
  assign cnt_b     = w_cnt[1];
  assign ovf_err   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_vertrees_rpt_merge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vertrees_rpt_merge
//  Description : Directed self-checking bench for vertrees_rpt_merge
//                (DW=8, DEPTH=4, CW=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vertrees_rpt_merge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_vld, b_vld, rpt_rdy;
  logic [7:0] a_data, b_data;
  logic       a_rdy, b_rdy, rpt_vld, rpt_src, ovf_err;
  logic [7:0] rpt_data;
  logic [3:0] cnt_a, cnt_b;

  int vec = 0;
  int err = 0;

  vertrees_rpt_merge #(.DW(8), .DEPTH(4), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rpt_a_vld(a_vld), .rpt_a_data(a_data), .rpt_a_rdy(a_rdy),
    .rpt_b_vld(b_vld), .rpt_b_data(b_data), .rpt_b_rdy(b_rdy),
    .rpt_vld(rpt_vld), .rpt_data(rpt_data), .rpt_src(rpt_src), .rpt_rdy(rpt_rdy),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    a_vld = 0; b_vld = 0; a_data = 0; b_data = 0; rpt_rdy = 0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [29:0] got;
    rst_n = 1'b0;
    a_vld = 0; b_vld = 0; a_data = 0; b_data = 0; rpt_rdy = 1;
    tick(); tick();
    got = {rpt_vld, rpt_data, rpt_src, cnt_a, cnt_b, ovf_err, a_rdy, b_rdy, 8'h00};
    vec++;
    if (got !== 30'd0) begin
      err++; $display("FAIL reset_outputs: got %h, want 0", got);
    end
    rst_n = 1'b1;
    #1;
    vec++;
    if ({a_rdy, b_rdy} !== 2'b00) begin
      err++; $display("FAIL rdy_before_edge: got %b, want 00", {a_rdy, b_rdy});
    end
    tick();
    vec++;
    if ({a_rdy, b_rdy} !== 2'b11) begin
      err++; $display("FAIL rdy_after_edge: got %b, want 11", {a_rdy, b_rdy});
    end
  endtask

  task automatic test_single();
    apply_reset();
    rpt_rdy = 1;
    a_vld = 1; a_data = 8'h5A;
    tick();
    a_vld = 0;
    vec++;
    if (rpt_vld !== 1'b0) begin
      err++; $display("FAIL single_latency: rpt_vld got %b, want 0 after edge 1", rpt_vld);
    end
    tick();
    vec++;
    if ({rpt_vld, rpt_src, rpt_data} !== {1'b1, 1'b0, 8'h5A}) begin
      err++; $display("FAIL single_out: vld/src/data got %b/%b/%h, want 1/0/5a", rpt_vld, rpt_src, rpt_data);
    end
    vec++;
    if (cnt_a !== 4'd1 || cnt_b !== 4'd0) begin
      err++; $display("FAIL single_cnt: cnt_a/cnt_b got %0d/%0d, want 1/0", cnt_a, cnt_b);
    end
    tick();
    vec++;
    if (rpt_vld !== 1'b0) begin
      err++; $display("FAIL single_drain: rpt_vld got %b, want 0", rpt_vld);
    end
  endtask

  task automatic test_alternate();
    logic [8:0] exp;
    apply_reset();
    rpt_rdy = 1;
    for (int t = 1; t <= 9; t++) begin
      if (t <= 4) begin
        a_vld = 1; a_data = 8'hA0 + 8'(t - 1);
        b_vld = 1; b_data = 8'hB0 + 8'(t - 1);
        vec++;
        if ({a_rdy, b_rdy} !== 2'b11) begin
          err++; $display("FAIL alt_stall: edge %0d rdy got %b, want 11", t, {a_rdy, b_rdy});
        end
      end else begin
        a_vld = 0; b_vld = 0;
      end
      tick();
      if (t >= 2) begin
        exp = ((t - 2) % 2 == 0) ? {1'b0, 8'hA0 + 8'((t - 2) / 2)}
                                 : {1'b1, 8'hB0 + 8'((t - 2) / 2)};
        vec++;
        if (rpt_vld !== 1'b1 || {rpt_src, rpt_data} !== exp) begin
          err++; $display("FAIL alt_order: edge %0d got vld=%b src=%b data=%h, want vld=1 src=%b data=%h",
                          t, rpt_vld, rpt_src, rpt_data, exp[8], exp[7:0]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rpt_rdy = 0;
    for (int i = 1; i <= 5; i++) begin
      a_vld = 1; a_data = 8'(i);
      vec++;
      if (a_rdy !== 1'b1) begin
        err++; $display("FAIL bp_accept: report %0d rdy got %b, want 1", i, a_rdy);
      end
      tick();
    end
    a_data = 8'h06;
    vec++;
    if (a_rdy !== 1'b0) begin
      err++; $display("FAIL bp_full: rpt_a_rdy got %b, want 0", a_rdy);
    end
    tick();
    a_vld = 0;
    vec++;
    if (rpt_vld !== 1'b1 || rpt_data !== 8'h01 || cnt_a !== 4'd5) begin
      err++; $display("FAIL bp_hold: vld/data/cnt got %b/%h/%0d, want 1/01/5", rpt_vld, rpt_data, cnt_a);
    end
    rpt_rdy = 1;
    for (int k = 1; k <= 5; k++) begin
      vec++;
      if (rpt_vld !== 1'b1 || rpt_data !== 8'(k) || rpt_src !== 1'b0) begin
        err++; $display("FAIL bp_order: step %0d got vld=%b data=%h src=%b, want 1/%h/0", k, rpt_vld, rpt_data, rpt_src, 8'(k));
      end
      tick();
    end
    vec++;
    if (rpt_vld !== 1'b0) begin
      err++; $display("FAIL bp_empty: rpt_vld got %b, want 0", rpt_vld);
    end
  endtask

  task automatic test_overflow();
    int  k;
    logic stalled;
    bit  seen;
    apply_reset();
    rpt_rdy = 0;
    b_vld = 1; b_data = 8'h33;
    k = 0; seen = 0;
    vec++;
    if (ovf_err !== 1'b0) begin
      err++; $display("FAIL ovf_initial: got %b, want 0", ovf_err);
    end
    for (int c = 0; c < 300 && !seen; c++) begin
      stalled = b_vld && !b_rdy;
      tick();
      if (stalled) begin
        k++;
        if (k == 255) begin
          vec++;
          if (ovf_err !== 1'b0) begin
            err++; $display("FAIL ovf_early: after 255 stalls got %b, want 0", ovf_err);
          end
        end
        if (k == 256) begin
          seen = 1;
          vec++;
          if (ovf_err !== 1'b1) begin
            err++; $display("FAIL ovf_rise: after 256 stalls got %b, want 1", ovf_err);
          end
        end
      end
    end
    if (!seen) begin
      vec++; err++;
      $display("FAIL ovf_budget: only %0d stalled cycles seen, want 256", k);
    end
    b_vld = 0; rpt_rdy = 1;
    for (int c = 0; c < 10; c++) tick();
    vec++;
    if (ovf_err !== 1'b1) begin
      err++; $display("FAIL ovf_sticky: got %b, want 1", ovf_err);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    rpt_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      a_vld = 1; a_data = 8'(i);
      tick();
      if (i == 13) begin
        vec++;
        if (cnt_a !== 4'd14) begin
          err++; $display("FAIL sat_mid: cnt_a got %0d, want 14", cnt_a);
        end
      end
    end
    a_vld = 0;
    tick();
    vec++;
    if (cnt_a !== 4'd15 || cnt_b !== 4'd0) begin
      err++; $display("FAIL sat_final: cnt_a/cnt_b got %0d/%0d, want 15/0", cnt_a, cnt_b);
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] got;
    apply_reset();
    rpt_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      a_vld = 1; a_data = 8'h71 + 8'(i);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {rpt_vld, rpt_data, rpt_src, cnt_a, cnt_b, ovf_err, a_rdy, b_rdy, 8'h00};
    vec++;
    if (got !== 30'd0) begin
      err++; $display("FAIL rstmid_outputs: got %h, want 0", got);
    end
    a_vld = 0;
    tick();
    rst_n = 1'b1;
    rpt_rdy = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      vec++;
      if (rpt_vld !== 1'b0 || cnt_a !== 4'd0) begin
        err++; $display("FAIL rstmid_stale: cycle %0d vld=%b data=%h cnt_a=%0d, want 0/-/0", c, rpt_vld, rpt_data, cnt_a);
      end
    end
    vec++;
    if ({a_rdy, b_rdy} !== 2'b11) begin
      err++; $display("FAIL rstmid_rdy: got %b, want 11", {a_rdy, b_rdy});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_overflow();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
`default_nettype wire
